// File: rtl/io_out_bridge.sv
// io_out_bridge
//
// Output side of the CPU memory-mapped I/O ports. The CPU writes a byte on
// IOD and flips IOE[0] to request a write. The bridge queues the byte in a
// small FIFO, answers on IOB with an ack toggle and the FIFO status, and
// presents queued bytes to an external consumer over valid/ready.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-low reset
//   IOD[7:0]   CPU data byte, held stable while a request is pending
//   IOE[7:0]   CPU control: [0] request toggle, [1] flush, [7:2] unused
//   IOB[7:0]   status: [0] ack toggle, [1] full, [2] empty, [7:3] count
//   OUT_DATA   byte at the FIFO head
//   OUT_VALID  FIFO non-empty
//   OUT_READY  consumer takes the head byte this cycle
//
// All outputs are decoded from registered state only; there is no
// input-to-output combinational path.

module io_out_bridge #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IOD,
    input  logic [7:0] IOE,
    output logic [7:0] IOB,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ack_q, ack_d;

    logic req_pend;
    logic flush;
    logic pop;
    logic push;
    logic full;
    logic empty;
    logic [4:0] count_ext;
    logic unused_ioe;

    assign unused_ioe = &{1'b0, IOE[7:2]};

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign req_pend = (IOE[0] != ack_q);
    assign flush    = IOE[1];
    assign pop      = !empty && OUT_READY && !flush;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push     = req_pend && !flush && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ack_d    = ack_q;

        if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = IOD;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                ack_d           = ~ack_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
        end
    end

    assign count_ext = 5'(count_q);
    assign IOB       = {count_ext, empty, full, ack_q};
    assign OUT_DATA  = mem_q[rd_ptr_q];
    assign OUT_VALID = !empty;

endmodule

// File: tb/tb_io_out_bridge.sv
module tb_io_out_bridge;

    logic       CLK;
    logic       RESET;
    logic [7:0] IOD;
    logic [7:0] IOE;
    logic [7:0] IOB;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    logic [7:0] exp_q [$];

    io_out_bridge #(.DEPTH(4), .ADDR_W(2)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IOD      (IOD),
        .IOE      (IOE),
        .IOB      (IOB),
        .OUT_DATA (OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Write with space available: byte is pushed at the edge ending this cycle.
    task automatic wr(input logic [7:0] b);
        IOD    = b;
        IOE[0] = ~IOE[0];
        exp_q.push_back(b);
        step();
    endtask

    task automatic do_reset();
        RESET     = 1'b0;
        IOE       = 8'h00;
        IOD       = 8'h00;
        OUT_READY = 1'b0;
        step();
        step();
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b1;
        #1;
    endtask

    // Monitor: compares every byte the consumer accepts against the scoreboard.
    always @(negedge CLK) begin
        if (RESET && OUT_VALID && OUT_READY && !IOE[1]) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got 0x%02h expected none at %0t", OUT_DATA, $time);
            end else begin
                check("out_data", OUT_DATA, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0;

        // Reset then idle
        do_reset();
        check("rst_iob", IOB, 8'h04);
        check("rst_valid", {7'b0, OUT_VALID}, 8'h00);
        check("rst_data", OUT_DATA, 8'h00);

        // Single write
        wr(8'hA5);
        check("single_iob", IOB, 8'h09);
        check("single_valid", {7'b0, OUT_VALID}, 8'h01);
        check("single_data", OUT_DATA, 8'hA5);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("single_drained_iob", IOB, 8'h05);

        // Fill and stall
        do_reset();
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        check("full_iob", IOB, 8'h22);
        IOD    = 8'h55;
        IOE[0] = 1'b1;
        exp_q.push_back(8'h55);
        step();
        check("stall_iob_1", IOB, 8'h22);
        step();
        check("stall_iob_2", IOB, 8'h22);
        OUT_READY = 1'b1;
        step();
        check("full_pop_push_iob", IOB, 8'h23);
        check("full_pop_head", OUT_DATA, 8'h22);
        repeat (4) step();
        OUT_READY = 1'b0;
        check("fill_drained_iob", IOB, 8'h05);

        // Wrap-around
        rx0 = rx_cnt;
        for (int i = 0; i < 10; i++) begin
            wr(8'h30 + 8'(i));
            OUT_READY = 1'b1;
            step();
            OUT_READY = 1'b0;
        end
        check("wrap_rx_count", 8'(rx_cnt - rx0), 8'd10);
        check("wrap_count", {3'b0, IOB[7:3]}, 8'h00);

        // Flush over a pending request
        wr(8'h66);
        wr(8'h77);
        check("preflush_iob", IOB, 8'h11);
        IOE[1] = 1'b1;
        IOD    = 8'h88;
        IOE[0] = ~IOE[0];
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_iob", IOB, 8'h05);
            check("flush_valid", {7'b0, OUT_VALID}, 8'h00);
        end
        IOE[1] = 1'b0;
        exp_q.push_back(8'h88);
        step();
        check("postflush_iob", IOB, 8'h08);
        check("postflush_data", OUT_DATA, 8'h88);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;

        // Async reset mid-stream
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        check("prereset_iob", IOB, 8'h19);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_iob", IOB, 8'h04);
        check("async_rst_valid", {7'b0, OUT_VALID}, 8'h00);
        check("async_rst_data", OUT_DATA, 8'h00);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b1;
        IOD   = 8'h99;
        exp_q.push_back(8'h99);
        step();
        check("rerequest_iob", IOB, 8'h09);
        check("rerequest_data", OUT_DATA, 8'h99);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        step();

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_out_bridge.md
# io_out_bridge

Peripheral at the external end of the data memory's memory-mapped I/O ports. The CPU writes a byte to IOD and flips a request bit on IOE. The bridge queues the byte in a small FIFO, returns an acknowledge toggle plus FIFO status on IOB, and presents the queued bytes to an external consumer over a valid/ready interface. The bridge clocks on the same CLK as the CPU and data memory.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- ADDR_W, 2: log2(DEPTH); pointer width. Count width is ADDR_W+1.
- CLK  input  1  single system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (RESET=0 clears all state immediately).
- IOD  input  8  CPU data byte; CPU holds it stable while its request is pending.
- IOE  input  8  CPU control: [0] request toggle; [1] flush; [7:2] ignored.
- IOB  output  8  status to CPU: [0] ack toggle; [1] full; [2] empty; [7:3] count, zero-extended.
- OUT_DATA  output  8  byte at the FIFO head.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  consumer accepts the head byte this cycle.

## Operation
- State: the ack register, storage of DEPTH×8 bits, rd_ptr and wr_ptr (ADDR_W bits each), and count (ADDR_W+1 bits).
- A request is pending when IOE[0] != ack.
- A pop occurs when OUT_VALID && OUT_READY && !IOE[1].
- A push occurs when the request is pending, IOE[1]=0, and either count<DEPTH or a pop occurs in the same cycle.
- On push:
  - mem[wr_ptr] <= IOD.
  - wr_ptr increments, wrapping modulo DEPTH.
  - ack <= ~ack.
- On pop: rd_ptr increments, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Flush (IOE[1]=1):
  - rd_ptr, wr_ptr and count go to 0 at the next edge.
  - No push and no pop occur.
  - ack is unchanged, so a pending request stays pending and is accepted in the first cycle after flush deasserts.
  - Storage contents are not cleared.
- Full (count==DEPTH) with no pop: the request stays pending and ack does not toggle. IOD must be held by the CPU. Full is not an error.
- Empty: OUT_VALID=0. OUT_READY is ignored.
- There is no bypass. A byte pushed into an empty FIFO appears on OUT_DATA/OUT_VALID the cycle after the push.
- Outputs are combinational from registered state only:
  - OUT_DATA = mem[rd_ptr].
  - OUT_VALID = (count!=0).
  - IOB[1] = (count==DEPTH).
  - IOB[2] = (count==0).
  - IOB[0] = ack.
  - No combinational path exists from any input to any output.
- A second CPU request can only start after the CPU observes IOB[0]==IOE[0]. Toggling IOE[0] again while a request is pending cancels that request; the CPU must not do this.

## Timing
- Reset values:
  - ack=0, rd_ptr=0, wr_ptr=0, count=0, all storage=0.
  - IOB=8'h04, OUT_DATA=8'h00, OUT_VALID=0.
- Reset asserted mid-transfer drops every queued byte and every pending request. After release, a CPU that left IOE[0]=1 sees a fresh pending request, because ack is back to 0.
- Request latency with space available:
  - IOE[0] flips in cycle N and the byte is pushed at the end of cycle N.
  - In cycle N+1, IOB[0] equals the new IOE[0], count has increased by 1, and OUT_VALID=1 if the FIFO was empty.
- Pop latency: a pop in cycle N updates OUT_DATA, count and the flags in cycle N+1.
- Full with simultaneous pop: the push is accepted in the same cycle, count stays at DEPTH, and ack toggles.
- Flush asserted for k cycles: the FIFO is empty from the first edge onward and stays empty until deassertion.

## Test plan
- Reset then idle: hold RESET=0 for 2 cycles, then release -> IOB=8'h04, OUT_VALID=0, OUT_DATA=8'h00.
- Single write: IOD=8'hA5, toggle IOE[0] to 1 with OUT_READY=0 -> next cycle IOB=8'h09 (ack=1, count=1), OUT_VALID=1, OUT_DATA=8'hA5.
- Fill and stall: write 8'h11, 8'h22, 8'h33, 8'h44, then request 8'h55 with OUT_READY=0 -> IOB=8'h22 (full, count=4, ack=0) and ack stays 0 while the request is pending. Then assert OUT_READY for 1 cycle -> 8'h11 pops, 8'h55 is pushed, and ack becomes 1. The consumer then drains 22, 33, 44, 55 in order.
- Wrap-around: perform 10 write/drain pairs with incrementing data -> every byte is received once, in order, and count ends at 0.
- Flush over a pending request: queue 2 bytes, raise IOE[1] for 3 cycles, and flip IOE[0] during the flush -> count=0, OUT_VALID=0 and ack is unchanged during the flush. One cycle after IOE[1] falls, the pending byte is accepted: count=1 and ack toggles.
- Async reset mid-stream: assert RESET=0 between clock edges with count=3 -> IOB=8'h04 and OUT_VALID=0 before the next edge.
